// File: rtl/minaret_fetch.sv
// Instruction fetch unit: issues sequential word fetches under a credit limit, buffers returned
// words in a small FIFO and hands them to the core. Redirects flush the buffer and discard
// responses that were already in flight.
module minaret_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW:0] DepthLimit = FIFO_DEPTH[CntW:0];

    typedef enum logic [0:0] {StFetch, StHalted} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_q, drop_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

    logic [31:0]           data_mem_q [FIFO_DEPTH];
    logic [31:0]           pc_mem_q   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] err_mem_q;

    logic [CntW:0]   credit_sum;
    logic [CntW-1:0] outstanding_after;
    logic            req_fire;
    logic            enq;
    logic            deq;
    logic [31:0]     redirect_aligned;

    // Request credit, handshakes and FIFO head presentation
    always_comb begin
        credit_sum       = {1'b0, outstanding_q} + {1'b0, count_q};
        // Held low while reset is asserted: the registers sit at values that would otherwise
        // allow a request.
        imem_req_valid   = !reset && (state_q == StFetch) && !redirect_valid &&
                           (credit_sum < DepthLimit);
        imem_req_addr    = fetch_pc_q;
        req_fire         = imem_req_valid && imem_req_ready;
        inst_valid       = (count_q != '0);
        deq              = inst_valid && inst_ready;
        // A response in the redirect cycle is stale; so is anything arriving while halted.
        enq              = imem_resp_valid && !redirect_valid && (drop_q == '0) &&
                           (state_q == StFetch);
        redirect_aligned = {redirect_pc[31:2], 2'b00};
        inst             = inst_valid ? data_mem_q[rd_ptr_q] : '0;
        inst_pc          = inst_valid ? pc_mem_q[rd_ptr_q] : '0;
        inst_fault       = inst_valid ? err_mem_q[rd_ptr_q] : 1'b0;
    end

    // Next-state for PCs, counters, FIFO pointers and fetch state
    always_comb begin
        state_d           = state_q;
        fetch_pc_d        = fetch_pc_q;
        resp_pc_d         = resp_pc_q;
        drop_d            = drop_q;
        wr_ptr_d          = wr_ptr_q;
        rd_ptr_d          = rd_ptr_q;
        outstanding_after = outstanding_q + CntW'(req_fire) - CntW'(imem_resp_valid);
        outstanding_d     = outstanding_after;
        count_d           = count_q + CntW'(enq) - CntW'(deq);

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (enq) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + 1'b1;
            if (imem_resp_err) begin
                state_d = StHalted;
            end
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (imem_resp_valid && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end

        // Redirect overrides everything: every request still in flight becomes stale.
        if (redirect_valid) begin
            state_d    = StFetch;
            fetch_pc_d = redirect_aligned;
            resp_pc_d  = redirect_aligned;
            drop_d     = outstanding_after;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StFetch;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Buffer storage; contents are only visible while count_q marks them valid
    always_ff @(posedge clk) begin
        if (enq) begin
            data_mem_q[wr_ptr_q] <= imem_resp_err ? 32'h0 : imem_resp_data;
            pc_mem_q[wr_ptr_q]   <= resp_pc_q;
            err_mem_q[wr_ptr_q]  <= imem_resp_err;
        end
    end

endmodule

// File: tb/tb_minaret_fetch.sv
// Self-checking bench for minaret_fetch: in-order memory model with configurable latency,
// expected-instruction scoreboard filled on request accept, plus directed corner cases.
module tb_minaret_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DATA_XOR = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    minaret_fetch #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .imem_resp_err  (imem_resp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
    } vec_t;

    mreq_t mq[$];
    exp_t  sb[$];
    bit    sb_halt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_lat = 1;
    bit mem_rdy, core_rdy, redir, err_en;
    logic [31:0] redir_pc, err_addr;
    int req_count, resp_count, inst_fires;
    int first_acc, first_iv;
    bit last_hs, last_resp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, observe mid-cycle, advance past the edge.
    task automatic tick();
        imem_req_ready = mem_rdy;
        inst_ready     = core_rdy;
        redirect_valid = redir;
        redirect_pc    = redir_pc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mq[0].addr ^ DATA_XOR;
            imem_resp_err   = err_en && (mq[0].addr == err_addr);
            void'(mq.pop_front());
            resp_count++;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
            imem_resp_err   = 1'b0;
        end
        @(negedge clk);
        last_hs   = inst_valid && inst_ready;
        last_resp = imem_resp_valid;
        if (inst_valid && first_iv < 0) first_iv = cyc;
        if (inst_valid && inst_ready) begin
            inst_fires++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_inst: got pc %h expected none (cycle %0d)", inst_pc,
                         cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("inst_pc", inst_pc, e.pc);
                chk("inst", inst, e.data);
                chk("inst_fault", 32'(inst_fault), 32'(e.fault));
            end
        end
        if (redirect_valid) begin
            sb.delete();
            sb_halt = 1'b0;
        end
        if (imem_req_valid && imem_req_ready) begin
            exp_t e;
            bit   f;
            if (first_acc < 0) first_acc = cyc;
            req_count++;
            mq.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
            f = err_en && (imem_req_addr == err_addr);
            if (!sb_halt) begin
                e.pc    = imem_req_addr;
                e.data  = f ? 32'h0 : (imem_req_addr ^ DATA_XOR);
                e.fault = f;
                sb.push_back(e);
                if (f) sb_halt = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reset DUT and memory model together; outputs must drop in the same cycle.
    task automatic do_reset();
        reset = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        imem_resp_err   = 1'b0;
        redirect_valid  = 1'b0;
        redir = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_fault", 32'(inst_fault), 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        mq.delete();
        sb.delete();
        sb_halt = 1'b0;
        req_count = 0;
        resp_count = 0;
        inst_fires = 0;
        first_acc = -1;
        first_iv = -1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        mem_rdy  = 1'b0;
        core_rdy = 1'b1;
        redir    = 1'b0;
        for (int i = 0; i < 40 && (mq.size() > 0 || sb.size() > 0); i++) tick();
        repeat (3) tick();
        chk("drain_left", sb.size(), 0);
    endtask

    initial begin
        vec_t vecs[4];
        int   n0;
        vecs[0] = '{rpc: 32'h0000_1003, exp_addr: 32'h0000_1000, exp_next: 32'h0000_1004};
        vecs[1] = '{rpc: 32'h0000_0042, exp_addr: 32'h0000_0040, exp_next: 32'h0000_0044};
        vecs[2] = '{rpc: 32'h8000_0001, exp_addr: 32'h8000_0000, exp_next: 32'h8000_0004};
        vecs[3] = '{rpc: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFFC, exp_next: 32'h0000_0000};

        imem_req_ready = 1'b0;
        inst_ready = 1'b0;
        redir_pc = 32'h0;
        redirect_pc = 32'h0;
        err_en = 1'b0;
        err_addr = 32'h0;
        mem_rdy = 1'b0;
        core_rdy = 1'b0;

        // Streaming at zero wait: 2-cycle latency, then one instruction per cycle
        do_reset();
        mem_lat = 1; mem_rdy = 1'b1; core_rdy = 1'b1;
        chk("first_req_addr", imem_req_addr, RESET_PC);
        repeat (22) tick();
        chk("first_latency", 32'(first_iv - first_acc), 32'd2);
        chk("throughput", 32'(inst_fires), 32'd20);
        drain();

        // Core stall: credit stops requests at four, head stays put
        do_reset();
        mem_rdy = 1'b1; core_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 1) begin
                chk("stall_valid", 32'(inst_valid), 32'd1);
                chk("stall_pc", inst_pc, 32'h0);
            end
        end
        chk("stall_reqs", 32'(req_count), 32'd4);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        n0 = inst_fires;
        drain();
        chk("stall_release_cnt", 32'(inst_fires - n0), 32'd4);

        // Redirect with two requests in flight at 3-cycle latency
        do_reset();
        mem_lat = 3; mem_rdy = 1'b1; core_rdy = 1'b1;
        repeat (2) tick();
        mem_rdy = 1'b0; redir = 1'b1; redir_pc = 32'h0000_1003;
        tick();
        chk("redir_addr", imem_req_addr, 32'h0000_1000);
        redir = 1'b0; mem_rdy = 1'b1;
        n0 = inst_fires;
        repeat (12) tick();
        chk("redir_progress", 32'(inst_fires > n0), 32'd1);
        drain();

        // Redirect coinciding with an inst handshake and a response
        do_reset();
        mem_lat = 1; mem_rdy = 1'b1; core_rdy = 1'b1;
        repeat (6) tick();
        redir = 1'b1; redir_pc = 32'h0000_2000;
        tick();
        chk("coinc_hs", 32'(last_hs), 32'd1);
        chk("coinc_resp", 32'(last_resp), 32'd1);
        redir = 1'b0;
        n0 = inst_fires;
        repeat (8) tick();
        chk("coinc_progress", 32'(inst_fires > n0), 32'd1);
        drain();

        // Fault on address 8 halts fetch until a redirect
        do_reset();
        err_en = 1'b1; err_addr = 32'h8;
        mem_rdy = 1'b1; core_rdy = 1'b1;
        repeat (15) tick();
        chk("halt_req_valid", 32'(imem_req_valid), 32'd0);
        chk("halt_reqs", 32'(req_count), 32'd4);
        chk("halt_insts", 32'(inst_fires), 32'd3);
        redir = 1'b1; redir_pc = 32'h0000_0100;
        tick();
        chk("halt_redir_addr", imem_req_addr, 32'h0000_0100);
        redir = 1'b0;
        n0 = inst_fires;
        repeat (8) tick();
        chk("halt_resume", 32'(inst_fires > n0), 32'd1);
        drain();
        err_en = 1'b0;

        // Redirect alignment table
        core_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_rdy = 1'b0; redir = 1'b1; redir_pc = vecs[i].rpc;
            tick();
            chk("tbl_gate", 32'(imem_req_valid), 32'd0);
            chk("tbl_addr", imem_req_addr, vecs[i].exp_addr);
            redir = 1'b0; mem_rdy = 1'b1;
            tick();
            chk("tbl_next", imem_req_addr, vecs[i].exp_next);
        end
        drain();

        // Reset with three buffered entries
        do_reset();
        mem_rdy = 1'b1; core_rdy = 1'b0;
        for (int i = 0; i < 20 && resp_count < 3; i++) tick();
        chk("pre_reset_valid", 32'(inst_valid), 32'd1);
        do_reset();
        mem_rdy = 1'b1; core_rdy = 1'b1;
        chk("post_reset_addr", imem_req_addr, RESET_PC);
        repeat (6) tick();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
